// File: rtl/wino_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wino_pkg
// Brief   : Shared types and constants for the Winograd F(2x2,3x3) datapath.
// Rev     : 1.0  initial release
// ============================================================================
package wino_pkg;

  localparam int WINO_TILE_ROWS      = 4;
  localparam int WINO_TILE_STRIDE    = 2;
  localparam int WINO_DEFAULT_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LO = 2'd1,
    ISSUE_HI = 2'd2,
    DONE     = 2'd3
  } wino_state_e;

endpackage
`default_nettype wire

// File: rtl/data_addr_gen_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter with synchronous clear that saturates at all-ones.
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : data_addr_gen
// Brief   : Dual-port row-address generator walking a feature map in
//           Winograd F(2x2,3x3) tile order. Optional perf counters are
//           enabled with the DATA_ADDR_GEN_PERF_EN macro.
// Rev     : 1.0  initial release
// ============================================================================
module data_addr_gen
  import wino_pkg::*;
#(
  parameter int ADDR_W = WINO_DEFAULT_ADDR_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_enable,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] cfg_base_addr_in,
  input  logic [CNT_W-1:0]  cfg_num_rows_in,
  input  logic [CNT_W-1:0]  cfg_num_ch_in,
  input  logic              addr_ready_in,
  output logic [ADDR_W-1:0] addr_1_out,
  output logic [ADDR_W-1:0] addr_2_out,
  output logic              addr_1_valid_out,
  output logic              addr_2_valid_out,
  output logic              tile_last_out,
  output logic              ch_last_out,
  output logic              busy_out,
  output logic              done_out
`ifdef DATA_ADDR_GEN_PERF_EN
  ,
  output logic [15:0]       stall_cnt_out,
  output logic [15:0]       issue_cnt_out
`endif
);

  wino_state_e       r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_ch_off;
  logic [CNT_W-1:0]  r_num_rows;
  logic [CNT_W-1:0]  r_tiles_m1;
  logic [CNT_W-1:0]  r_ch_m1;
  logic [CNT_W-1:0]  r_t;
  logic [CNT_W-1:0]  r_c;

  logic              w_start;
  logic [CNT_W-1:0]  w_tiles;
  logic [ADDR_W-1:0] w_next_ch_row;
  logic              w_tile_last_next;
  logic              w_ch_last_next;

  assign w_start = (r_state == IDLE) && start_in && !scan_enable;

  // Fewer than one full 4-row tile means nothing to issue; odd H drops a row.
  assign w_tiles = (cfg_num_rows_in < CNT_W'(WINO_TILE_ROWS)) ? '0 :
                   ((cfg_num_rows_in - CNT_W'(WINO_TILE_STRIDE)) >> 1);

  assign w_next_ch_row    = r_base + r_ch_off + ADDR_W'(r_num_rows);
  assign w_tile_last_next = (r_t == r_tiles_m1);
  assign w_ch_last_next   = w_tile_last_next && (r_c == r_ch_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_base           <= '0;
      r_ch_off         <= '0;
      r_num_rows       <= '0;
      r_tiles_m1       <= '0;
      r_ch_m1          <= '0;
      r_t              <= '0;
      r_c              <= '0;
      addr_1_out       <= '0;
      addr_2_out       <= '0;
      addr_1_valid_out <= 1'b0;
      addr_2_valid_out <= 1'b0;
      tile_last_out    <= 1'b0;
      ch_last_out      <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done_out <= 1'b0;
          if (w_start) begin
            r_base     <= cfg_base_addr_in;
            r_num_rows <= cfg_num_rows_in;
            r_tiles_m1 <= w_tiles - CNT_W'(1);
            r_ch_m1    <= cfg_num_ch_in - CNT_W'(1);
            r_t        <= '0;
            r_c        <= '0;
            r_ch_off   <= '0;
            busy_out   <= 1'b1;
            if ((w_tiles == '0) || (cfg_num_ch_in == '0)) begin
              r_state  <= DONE;
              done_out <= 1'b1;
            end else begin
              r_state          <= ISSUE_LO;
              addr_1_out       <= cfg_base_addr_in;
              addr_2_out       <= cfg_base_addr_in + ADDR_W'(1);
              addr_1_valid_out <= 1'b1;
              addr_2_valid_out <= 1'b1;
            end
          end
        end

        ISSUE_LO, ISSUE_HI: begin
          if (scan_enable) begin
            r_state          <= IDLE;
            addr_1_valid_out <= 1'b0;
            addr_2_valid_out <= 1'b0;
            tile_last_out    <= 1'b0;
            ch_last_out      <= 1'b0;
            busy_out         <= 1'b0;
          end else if (addr_ready_in) begin
            if (r_state == ISSUE_LO) begin
              r_state       <= ISSUE_HI;
              addr_1_out    <= addr_1_out + ADDR_W'(WINO_TILE_STRIDE);
              addr_2_out    <= addr_2_out + ADDR_W'(WINO_TILE_STRIDE);
              tile_last_out <= w_tile_last_next;
              ch_last_out   <= w_ch_last_next;
            end else begin
              tile_last_out <= 1'b0;
              ch_last_out   <= 1'b0;
              if (!w_tile_last_next) begin
                // The HI pair of tile t is already the LO pair of tile t+1.
                r_state <= ISSUE_LO;
                r_t     <= r_t + CNT_W'(1);
              end else if (r_c != r_ch_m1) begin
                r_state    <= ISSUE_LO;
                r_t        <= '0;
                r_c        <= r_c + CNT_W'(1);
                r_ch_off   <= r_ch_off + ADDR_W'(r_num_rows);
                addr_1_out <= w_next_ch_row;
                addr_2_out <= w_next_ch_row + ADDR_W'(1);
              end else begin
                r_state          <= DONE;
                addr_1_valid_out <= 1'b0;
                addr_2_valid_out <= 1'b0;
                done_out         <= 1'b1;
              end
            end
          end
        end

        DONE: begin
          r_state  <= IDLE;
          done_out <= 1'b0;
          busy_out <= 1'b0;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DATA_ADDR_GEN_PERF_EN
  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .inc   (addr_1_valid_out && !addr_ready_in),
    .count (stall_cnt_out)
  );

  sat_counter #(.WIDTH(16)) u_issue_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .inc   (addr_1_valid_out && addr_ready_in && !scan_enable),
    .count (issue_cnt_out)
  );
`else
`endif

endmodule
`default_nettype wire
